// File: rtl/hash_msg_streamer.sv
// Host-side front end for the hash core: buffers one byte string, streams it
// to the core, then returns the digest with overflow/timeout flags.
module hash_msg_streamer #(
    parameter int DEPTH   = 64,
    parameter int LEN_W   = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [7:0]              in_data,
    input  logic                    in_last,
    output logic [7:0]              M,
    output logic                    M_valid,
    output logic [LEN_W-1:0]        input_lenght,
    input  logic                    hash_ready,
    input  logic [31:0]             digest,
    output logic                    dig_valid,
    input  logic                    dig_ready,
    output logic [31:0]             dig_data,
    output logic [$clog2(DEPTH):0]  dig_len,
    output logic                    err_ovf,
    output logic                    err_timeout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        LOAD,
        DISCARD,
        SEND,
        WAIT,
        RESULT
    } state_t;

    state_t         state, state_n;
    logic [CW-1:0]  count, count_n;
    logic [CW-1:0]  len, len_n;
    logic [CW-1:0]  k, k_n;
    logic [TW-1:0]  timer, timer_n;
    logic [7:0]     mem [DEPTH];
    logic           wr;
    logic           accept;
    logic           in_ready_n;
    logic [7:0]     m_n;
    logic           m_valid_n;
    logic           dig_valid_n;
    logic [31:0]    dig_data_n;
    logic           ovf_n;
    logic           to_n;

    assign accept       = in_valid && in_ready;
    assign input_lenght = LEN_W'(len);
    assign dig_len      = len;

    always_comb begin
        state_n     = state;
        count_n     = count;
        len_n       = len;
        k_n         = k;
        timer_n     = timer;
        m_n         = M;
        m_valid_n   = 1'b0;
        dig_valid_n = dig_valid;
        dig_data_n  = dig_data;
        ovf_n       = err_ovf;
        to_n        = err_timeout;
        wr          = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    wr      = 1'b1;
                    count_n = count + CW'(1);
                    if (in_last) begin
                        len_n   = count + CW'(1);
                        state_n = SEND;
                    end else if (count == CW'(DEPTH - 1)) begin
                        len_n   = CW'(DEPTH);
                        ovf_n   = 1'b1;
                        state_n = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (accept && in_last) state_n = SEND;
            end
            SEND: begin
                if (k == len) begin
                    m_n     = 8'h00;
                    timer_n = '0;
                    state_n = WAIT;
                end else begin
                    m_n       = mem[k[AW-1:0]];
                    m_valid_n = 1'b1;
                    k_n       = k + CW'(1);
                end
            end
            WAIT: begin
                // A response on the timeout cycle still counts as success.
                if (hash_ready) begin
                    dig_data_n  = digest;
                    dig_valid_n = 1'b1;
                    state_n     = RESULT;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    dig_data_n  = 32'h0;
                    to_n        = 1'b1;
                    dig_valid_n = 1'b1;
                    state_n     = RESULT;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            RESULT: begin
                if (dig_ready) begin
                    dig_valid_n = 1'b0;
                    ovf_n       = 1'b0;
                    to_n        = 1'b0;
                    count_n     = '0;
                    len_n       = '0;
                    state_n     = LOAD;
                end
            end
            default: state_n = LOAD;
        endcase
        // First byte goes out on the entry edge; a 1-byte string bypasses mem.
        if (state != SEND && state_n == SEND) begin
            m_n       = (state == LOAD && count == '0) ? in_data : mem[0];
            m_valid_n = 1'b1;
            k_n       = CW'(1);
        end
        in_ready_n = (state_n == LOAD && count_n < CW'(DEPTH))
                     || state_n == DISCARD;
    end

    always_ff @(posedge clk) begin
        if (wr) mem[count[AW-1:0]] <= in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= LOAD;
            count       <= '0;
            len         <= '0;
            k           <= '0;
            timer       <= '0;
            in_ready    <= 1'b0;
            M           <= 8'h00;
            M_valid     <= 1'b0;
            dig_valid   <= 1'b0;
            dig_data    <= 32'h0;
            err_ovf     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            count       <= count_n;
            len         <= len_n;
            k           <= k_n;
            timer       <= timer_n;
            in_ready    <= in_ready_n;
            M           <= m_n;
            M_valid     <= m_valid_n;
            dig_valid   <= dig_valid_n;
            dig_data    <= dig_data_n;
            err_ovf     <= ovf_n;
            err_timeout <= to_n;
        end
    end
endmodule

// File: tb/tb_hash_msg_streamer.sv
// Bench for hash_msg_streamer: host driver, behavioural hash-core stub and
// a string-level reference model.
module tb_hash_msg_streamer;
    localparam int DEPTH   = 8;
    localparam int LEN_W   = 64;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_data = 8'h00;
    logic             in_last = 1'b0;
    logic [7:0]       M;
    logic             M_valid;
    logic [LEN_W-1:0] input_lenght;
    logic             hash_ready;
    logic [31:0]      digest;
    logic             dig_valid;
    logic             dig_ready = 1'b0;
    logic [31:0]      dig_data;
    logic [CW-1:0]    dig_len;
    logic             err_ovf;
    logic             err_timeout;

    int checks = 0;
    int errors = 0;

    hash_msg_streamer #(
        .DEPTH(DEPTH),
        .LEN_W(LEN_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .M(M),
        .M_valid(M_valid),
        .input_lenght(input_lenght),
        .hash_ready(hash_ready),
        .digest(digest),
        .dig_valid(dig_valid),
        .dig_ready(dig_ready),
        .dig_data(dig_data),
        .dig_len(dig_len),
        .err_ovf(err_ovf),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_hash(input logic [7:0] b[$]);
        logic [31:0] h = 32'h811C9DC5;
        foreach (b[i]) h = (h ^ {24'h0, b[i]}) * 32'h01000193;
        return h ^ 32'(b.size());
    endfunction

    // Hash-core stub: restarts on the first M_valid byte, keeps a stale
    // hash_ready until then, answers stub_delay edges after M_valid drops.
    logic [7:0]       core_bytes[$];
    logic [LEN_W-1:0] core_len = '0;
    logic             len_changed = 1'b0;
    logic             mv_prev_s = 1'b0;
    logic             busy = 1'b0;
    int               scnt = 0;
    int               stub_delay = 0;
    logic             core_en = 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            hash_ready <= 1'b0;
            digest     <= 32'h0;
            busy       <= 1'b0;
            mv_prev_s  <= 1'b0;
        end else begin
            if (M_valid) begin
                if (!mv_prev_s) begin
                    core_bytes.delete();
                    core_len    <= input_lenght;
                    len_changed <= 1'b0;
                end else if (input_lenght != core_len) begin
                    len_changed <= 1'b1;
                end
                core_bytes.push_back(M);
                hash_ready <= 1'b0;
                busy       <= 1'b1;
                scnt       <= 0;
            end else if (busy && core_en) begin
                if (scnt >= stub_delay) begin
                    hash_ready <= 1'b1;
                    digest     <= ref_hash(core_bytes);
                    busy       <= 1'b0;
                end else begin
                    scnt <= scnt + 1;
                end
            end
            mv_prev_s <= M_valid;
        end
    end

    int   cyc = 0;
    int   mv_fall_cyc = 0;
    int   dv_rise_cyc = 0;
    int   mv_total = 0;
    logic mv_q = 1'b0;
    logic dv_q = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!M_valid && mv_q) mv_fall_cyc <= cyc;
        if (dig_valid && !dv_q) dv_rise_cyc <= cyc;
        if (M_valid) mv_total <= mv_total + 1;
        mv_q <= M_valid;
        dv_q <= dig_valid;
    end

    task automatic send_str(input logic [7:0] s[$], input bit gaps,
                            output int stalls);
        int g;
        stalls = 0;
        foreach (s[i]) begin
            @(negedge clk);
            if (gaps) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = s[i];
            in_last  = (i == s.size() - 1);
            g = 0;
            while (!in_ready && g < 200) begin
                stalls++;
                @(negedge clk);
                g++;
            end
            if (g == 200) begin
                checks++;
                errors++;
                $display("FAIL send_handshake: in_ready=%b after %0d cycles, required 1",
                         in_ready, g);
            end
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input int hold, output bit got,
                               output logic [31:0] d, output logic [CW-1:0] l,
                               output logic ovf, output logic to);
        got = 0;
        d = '0;
        l = '0;
        ovf = 1'b0;
        to = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (dig_valid) got = 1;
        end
        if (got) begin
            d   = dig_data;
            l   = dig_len;
            ovf = err_ovf;
            to  = err_timeout;
            repeat (hold) @(negedge clk);
            dig_ready = 1'b1;
            @(negedge clk);
            dig_ready = 1'b0;
        end
    endtask

    task automatic check_string(input string nm, input logic [7:0] s[$],
                                input bit got, input logic [31:0] d,
                                input logic [CW-1:0] l, input logic ovf,
                                input logic to);
        logic [7:0] tq[$];
        int m;
        int bad;
        m = (s.size() > DEPTH) ? DEPTH : s.size();
        tq = s[0:m-1];
        checks++;
        if (got !== 1'b1) begin
            errors++;
            $display("FAIL %s_result: dig_valid never seen, required 1", nm);
        end
        checks++;
        if (d !== ref_hash(tq)) begin
            errors++;
            $display("FAIL %s_digest: got %h, required %h", nm, d, ref_hash(tq));
        end
        checks++;
        if (l !== CW'(m)) begin
            errors++;
            $display("FAIL %s_dig_len: got %0d, required %0d", nm, l, m);
        end
        checks++;
        if ({ovf, to} !== {s.size() > DEPTH, 1'b0}) begin
            errors++;
            $display("FAIL %s_flags: ovf/to %b%b, required %b0", nm, ovf, to,
                     s.size() > DEPTH);
        end
        bad = (core_bytes.size() != m) ? 1 : 0;
        foreach (core_bytes[i]) if (i < m && core_bytes[i] !== tq[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_core_bytes: got %0d bytes, required %0d matching bytes",
                     nm, core_bytes.size(), m);
        end
        checks++;
        if (core_len !== LEN_W'(m) || len_changed) begin
            errors++;
            $display("FAIL %s_input_lenght: got %0d (changed=%b), required %0d stable",
                     nm, core_len, len_changed, m);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, M, M_valid, input_lenght, dig_valid, dig_data, dig_len,
             err_ovf, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: in_ready=%b M_valid=%b dig_valid=%b dig_data=%h, required all 0",
                     in_ready, M_valid, dig_valid, dig_data);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] s[$] = '{8'h61};
        bit got; logic [31:0] d; logic [CW-1:0] l; logic ovf, to;
        int st, mv0;
        stub_delay = 0;
        mv0 = mv_total;
        send_str(s, 0, st);
        wait_result(0, got, d, l, ovf, to);
        check_string("single", s, got, d, l, ovf, to);
        checks++;
        if (dv_rise_cyc - mv_fall_cyc != 2) begin
            errors++;
            $display("FAIL single_latency: got %0d, required 2",
                     dv_rise_cyc - mv_fall_cyc);
        end
        checks++;
        if (mv_total - mv0 != 1) begin
            errors++;
            $display("FAIL single_mvalid_cycles: got %0d, required 1", mv_total - mv0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s[$] = '{8'h61, 8'h62, 8'h63};
        bit got; logic [31:0] d1, d2; logic [CW-1:0] l; logic ovf, to;
        int st, mv0;
        stub_delay = 1;
        for (int r = 0; r < 2; r++) begin
            mv0 = mv_total;
            send_str(s, 0, st);
            wait_result(0, got, d2, l, ovf, to);
            check_string("abc", s, got, d2, l, ovf, to);
            checks++;
            if (mv_total - mv0 != 3) begin
                errors++;
                $display("FAIL abc_mvalid_cycles: got %0d, required 3", mv_total - mv0);
            end
            if (r == 0) d1 = d2;
        end
        checks++;
        if (d2 !== d1) begin
            errors++;
            $display("FAIL abc_repeat: got %h, required %h", d2, d1);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] s[$];
        bit got; logic [31:0] d; logic [CW-1:0] l; logic ovf, to;
        int st;
        for (int i = 1; i <= DEPTH + 2; i++) s.push_back(8'(i));
        stub_delay = 0;
        send_str(s, 0, st);
        wait_result(0, got, d, l, ovf, to);
        check_string("ovf", s, got, d, l, ovf, to);
        checks++;
        if (st != 0) begin
            errors++;
            $display("FAIL ovf_in_ready_stalls: got %0d, required 0", st);
        end
    endtask

    task automatic test_timeout();
        logic [7:0] s[$] = '{8'h10, 8'h20, 8'h30};
        bit got; logic [31:0] d; logic [CW-1:0] l; logic ovf, to;
        int st;
        core_en = 1'b0;
        send_str(s, 0, st);
        wait_result(0, got, d, l, ovf, to);
        checks++;
        if (got !== 1'b1 || to !== 1'b1 || d !== 32'h0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL timeout_result: got=%b to=%b data=%h ovf=%b, required 1 1 0 0",
                     got, to, d, ovf);
        end
        checks++;
        if (l !== CW'(3)) begin
            errors++;
            $display("FAIL timeout_dig_len: got %0d, required 3", l);
        end
        checks++;
        if (dv_rise_cyc - mv_fall_cyc != TIMEOUT) begin
            errors++;
            $display("FAIL timeout_latency: got %0d, required %0d",
                     dv_rise_cyc - mv_fall_cyc, TIMEOUT);
        end
        core_en = 1'b1;
    endtask

    task automatic test_hold();
        logic [7:0] s[$] = '{8'h5A, 8'hA5, 8'h3C, 8'hC3};
        logic [31:0] d0; logic [CW-1:0] l0;
        int st, g, bad;
        stub_delay = 2;
        send_str(s, 0, st);
        g = 0;
        while (!dig_valid && g < 200) begin
            @(negedge clk);
            g++;
        end
        d0 = dig_data;
        l0 = dig_len;
        checks++;
        if (d0 !== ref_hash(s) || l0 !== CW'(4)) begin
            errors++;
            $display("FAIL hold_result: got %h/%0d, required %h/4", d0, l0, ref_hash(s));
        end
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (dig_valid !== 1'b1 || dig_data !== d0 || dig_len !== l0
                || in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
        end
        dig_ready = 1'b1;
        @(negedge clk);
        dig_ready = 1'b0;
        checks++;
        if (dig_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: dig_valid=%b in_ready=%b, required 0 1",
                     dig_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_send();
        logic [7:0] s[$];
        bit got; logic [31:0] d; logic [CW-1:0] l; logic ovf, to;
        int st, seen;
        for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
        stub_delay = 0;
        send_str(s, 0, st);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (M_valid !== 1'b0 || in_ready !== 1'b0 || dig_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: M_valid=%b in_ready=%b dig_valid=%b, required 0",
                     M_valid, in_ready, dig_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (dig_valid || M_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midreset_no_result: %0d active cycles, required 0", seen);
        end
        s.delete();
        for (int i = 0; i < 5; i++) s.push_back(8'($urandom));
        send_str(s, 0, st);
        wait_result(0, got, d, l, ovf, to);
        check_string("after_reset", s, got, d, l, ovf, to);
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        bit got; logic [31:0] d; logic [CW-1:0] l; logic ovf, to;
        int st, n;
        for (int t = 0; t < 25; t++) begin
            s.delete();
            n = $urandom_range(1, DEPTH + 3);
            for (int i = 0; i < n; i++) s.push_back(8'($urandom));
            stub_delay = $urandom_range(0, 5);
            dig_ready = 1'($urandom_range(0, 1));
            send_str(s, 1'($urandom_range(0, 1)), st);
            wait_result($urandom_range(0, 3), got, d, l, ovf, to);
            check_string("random", s, got, d, l, ovf, to);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_timeout();
        test_hold();
        test_reset_mid_send();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hash_msg_streamer.md
Name: hash_msg_streamer

Overview:
- Host-side front end for the light DES-s-box hash core.
- Buffers one complete byte string from a host valid/ready stream.
- Streams the buffered string into the core's byte interface (M, M_valid, input_lenght), then waits for hash_ready.
- Returns the 32-bit digest to the host through a valid/ready result port, with overflow and timeout flags.

Parameters:
DEPTH, 64, message buffer size in bytes (power of 2, ≥2); max message length
LEN_W, 64, width of input_lenght toward the core
TIMEOUT, 1024, max cycles in WAIT for hash_ready before aborting

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
in_valid  in  1  host byte valid
in_ready  out  1  streamer accepts host byte
in_data  in  8  host byte
in_last  in  1  byte is final byte of string
M  out  8  byte to hash core
M_valid  out  1  byte to core valid
input_lenght  out  LEN_W  string length to core, zero-extended
hash_ready  in  1  core digest valid
digest  in  32  core digest
dig_valid  out  1  result valid
dig_ready  in  1  host accepts result
dig_data  out  32  captured digest; 0 on timeout
dig_len  out  $clog2(DEPTH)+1  bytes actually hashed
err_ovf  out  1  string longer than DEPTH; truncated
err_timeout  out  1  core did not respond within TIMEOUT

Behaviour:
- Outputs are registered. While rst is high, every output is 0 and the state is LOAD; counters and flags clear. The core's rst_n is tied to ~rst at system level.
- States: LOAD, DISCARD, SEND, WAIT, RESULT.
- LOAD
  - in_ready = 1 while count < DEPTH.
  - On in_valid && in_ready: mem[count] <= in_data; count++.
  - If in_last: len <= count+1, go to SEND.
  - If the DEPTH-th byte is accepted without in_last: len <= DEPTH, err_ovf <= 1, go to DISCARD.
- DISCARD
  - in_ready = 1; bytes are dropped.
  - On an accepted in_last, go to SEND.
- SEND
  - in_ready = 0; input_lenght = len, held stable through SEND and WAIT.
  - Drive M = mem[k], M_valid = 1, for k = 0..len-1 on consecutive cycles, with no bubbles.
  - After byte len-1, M_valid <= 0 and go to WAIT.
- M_valid must never be 1 outside SEND. Otherwise the core re-initialises after its final state.
- The core needs len+1 rising edges after the first SEND edge to raise hash_ready.
- A stale hash_ready=1 from the previous string may be visible during SEND. hash_ready is sampled only in WAIT.
- WAIT
  - timer counts from 0.
  - On hash_ready = 1: dig_data <= digest, go to RESULT.
  - On timer == TIMEOUT-1 without hash_ready: dig_data <= 0, err_timeout <= 1, go to RESULT.
  - hash_ready arriving on the same cycle as the timeout wins: no error.
- RESULT
  - dig_valid = 1; dig_data, dig_len = len, and the flags are stable.
  - On dig_ready: dig_valid <= 0, flags and count clear, go to LOAD.
  - dig_ready is ignored when dig_valid = 0.
- Zero-length strings cannot be produced, since in_last always carries a byte. len ≥ 1.
- Reset mid-operation: immediate return to LOAD with all outputs 0. A partially buffered string is discarded, and no result is emitted.

Test Plan:
- Reset then one byte 0x61 with in_last → SEND lasts 1 cycle (M = 0x61, input_lenght = 1). Against the real core, dig_valid rises 2 cycles after the SEND cycle; dig_data matches the golden model; dig_len = 1; both flags 0.
- "abc" (0x61, 0x62, 0x63), then a second string "abc" issued back-to-back → identical dig_data for both, proving the stale hash_ready is not sampled. M_valid is high for exactly 3 cycles per string.
- DEPTH = 4, host sends 6 bytes 0x01..0x06 with last on 0x06 → in_ready stays 1 throughout. Core receives 0x01..0x04 with input_lenght = 4; dig_len = 4; err_ovf = 1.
- Core stubbed with hash_ready = 0, TIMEOUT = 16 → dig_valid rises 16 cycles after WAIT entry, with err_timeout = 1 and dig_data = 0.
- Hold dig_ready low for 10 cycles in RESULT → dig_valid and dig_data stay stable and in_ready = 0. Raise dig_ready → the next cycle is in LOAD with in_ready = 1.
- Assert rst during SEND of an 8-byte string → M_valid = 0 at once and no dig_valid. A new string afterwards hashes correctly.
